// File: rtl/umi_gpio_responder.sv
// UMI responder mapping byte-addressed reads/writes onto gpio_in / gpio_out.
// Optional input synchronizer: define UMI_GPIO_RESPONDER_SYNC_EN.
module umi_gpio_responder #(
    parameter int IWIDTH = 128,
    parameter int OWIDTH = 384,
    parameter int DW     = 256,
    parameter int AW     = 64,
    parameter int CW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              udev_req_valid,
    output logic              udev_req_ready,
    input  logic [CW-1:0]     udev_req_cmd,
    input  logic [AW-1:0]     udev_req_dstaddr,
    input  logic [AW-1:0]     udev_req_srcaddr,
    input  logic [DW-1:0]     udev_req_data,
    output logic              udev_resp_valid,
    input  logic              udev_resp_ready,
    output logic [CW-1:0]     udev_resp_cmd,
    output logic [AW-1:0]     udev_resp_dstaddr,
    output logic [AW-1:0]     udev_resp_srcaddr,
    output logic [DW-1:0]     udev_resp_data,
    input  logic [IWIDTH-1:0] gpio_in,
    output logic [OWIDTH-1:0] gpio_out
);
    localparam int IB = IWIDTH / 8;
    localparam int OB = OWIDTH / 8;
    localparam int DB = DW / 8;

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] REQ_POSTED = 5'h05;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] RESP_WRITE = 5'h04;

    typedef enum logic {IDLE, RESP} state_t;

    state_t                 state;
    logic [OB-1:0][7:0]     out_q;
    logic [OB-1:0][7:0]     wr_next;
    logic [DB-1:0][7:0]     rd_next;
    logic [DB-1:0][7:0]     req_bytes;
    logic [DB-1:0][7:0]     resp_data_q;
    logic [IB-1:0][7:0]     in_bytes;
    logic [IWIDTH-1:0]      rd_src;
    logic [4:0]             opcode;
    logic [2:0]             size;
    logic [7:0]             len;
    logic [31:0]            nbytes_raw;
    logic [31:0]            nbytes;
    logic                   accept;

    assign opcode     = udev_req_cmd[4:0];
    assign size       = udev_req_cmd[7:5];
    assign len        = udev_req_cmd[15:8];
    assign nbytes_raw = ({24'd0, len} + 32'd1) << size;
    assign nbytes     = (nbytes_raw > 32'(DB)) ? 32'(DB) : nbytes_raw;

    assign udev_req_ready = (state == IDLE) && !rst;
    assign accept         = udev_req_valid && udev_req_ready;
    assign req_bytes      = udev_req_data;
    assign gpio_out       = out_q;
    assign udev_resp_data = resp_data_q;

`ifdef UMI_GPIO_RESPONDER_SYNC_EN
    logic [IWIDTH-1:0] sync1, sync2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
        end
    end
    assign rd_src = sync2;
`else
    assign rd_src = gpio_in;
`endif

    assign in_bytes = rd_src;

    // Output lane j is hit when j-dstaddr is non-negative and below nbytes;
    // the borrow bit rejects lanes below dstaddr, including wrapped addresses.
    for (genvar j = 0; j < OB; j++) begin : g_wr
        logic [AW:0] off;
        logic        hit;
        assign off        = (AW+1)'(j) - {1'b0, udev_req_dstaddr};
        assign hit        = !off[AW] && (off[AW-1:0] < AW'(nbytes));
        assign wr_next[j] = hit ? req_bytes[off[$clog2(DB)-1:0]] : out_q[j];
    end

    // Read lane k uses a carry-extended sum so wrap past 2^AW is out of range.
    for (genvar k = 0; k < DB; k++) begin : g_rd
        logic [AW:0] addr;
        logic        hit;
        assign addr       = {1'b0, udev_req_dstaddr} + (AW+1)'(k);
        assign hit        = (32'(k) < nbytes) && (addr < (AW+1)'(IB));
        assign rd_next[k] = hit ? in_bytes[addr[$clog2(IB)-1:0]] : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            out_q             <= '0;
            udev_resp_valid   <= 1'b0;
            udev_resp_cmd     <= '0;
            udev_resp_dstaddr <= '0;
            udev_resp_srcaddr <= '0;
            resp_data_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (opcode)
                            REQ_POSTED: out_q <= wr_next;
                            REQ_WRITE: begin
                                out_q             <= wr_next;
                                udev_resp_cmd     <= {udev_req_cmd[CW-1:5], RESP_WRITE};
                                udev_resp_dstaddr <= udev_req_srcaddr;
                                udev_resp_srcaddr <= udev_req_dstaddr;
                                resp_data_q       <= '0;
                                udev_resp_valid   <= 1'b1;
                                state             <= RESP;
                            end
                            REQ_READ: begin
                                udev_resp_cmd     <= {udev_req_cmd[CW-1:5], RESP_READ};
                                udev_resp_dstaddr <= udev_req_srcaddr;
                                udev_resp_srcaddr <= udev_req_dstaddr;
                                resp_data_q       <= rd_next;
                                udev_resp_valid   <= 1'b1;
                                state             <= RESP;
                            end
                            default: ;
                        endcase
                    end
                end
                RESP: begin
                    if (udev_resp_ready) begin
                        udev_resp_valid <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_umi_gpio_responder.sv
// Randomized bench for umi_gpio_responder against a byte-array reference model.
module tb_umi_gpio_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         udev_req_valid = 1'b0;
    logic         udev_req_ready;
    logic [31:0]  udev_req_cmd = '0;
    logic [63:0]  udev_req_dstaddr = '0;
    logic [63:0]  udev_req_srcaddr = '0;
    logic [255:0] udev_req_data = '0;
    logic         udev_resp_valid;
    logic         udev_resp_ready = 1'b0;
    logic [31:0]  udev_resp_cmd;
    logic [63:0]  udev_resp_dstaddr;
    logic [63:0]  udev_resp_srcaddr;
    logic [255:0] udev_resp_data;
    logic [127:0] gpio_in = '0;
    logic [383:0] gpio_out;

    int n_chk = 0;
    int n_fail = 0;
    logic [383:0] m_out = '0;

    umi_gpio_responder dut (
        .clk(clk), .rst(rst),
        .udev_req_valid(udev_req_valid), .udev_req_ready(udev_req_ready),
        .udev_req_cmd(udev_req_cmd), .udev_req_dstaddr(udev_req_dstaddr),
        .udev_req_srcaddr(udev_req_srcaddr), .udev_req_data(udev_req_data),
        .udev_resp_valid(udev_resp_valid), .udev_resp_ready(udev_resp_ready),
        .udev_resp_cmd(udev_resp_cmd), .udev_resp_dstaddr(udev_resp_dstaddr),
        .udev_resp_srcaddr(udev_resp_srcaddr), .udev_resp_data(udev_resp_data),
        .gpio_in(gpio_in), .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [31:0] cmd);
        int n;
        n = (int'(cmd[15:8]) + 1) << cmd[7:5];
        return (n > 32) ? 32 : n;
    endfunction

    function automatic void model_write(input logic [63:0] dst, input logic [31:0] cmd,
                                        input logic [255:0] data);
        logic [64:0] a;
        for (int k = 0; k < nbytes_of(cmd); k++) begin
            a = {1'b0, dst} + 65'(k);
            if (a < 65'd48) m_out[8*int'(a) +: 8] = data[8*k +: 8];
        end
    endfunction

    function automatic logic [255:0] model_read(input logic [63:0] dst, input logic [31:0] cmd,
                                                input logic [127:0] pins);
        logic [255:0] r;
        logic [64:0]  a;
        r = '0;
        for (int k = 0; k < nbytes_of(cmd); k++) begin
            a = {1'b0, dst} + 65'(k);
            if (a < 65'd16) r[8*k +: 8] = pins[8*int'(a) +: 8];
        end
        return r;
    endfunction

    // One full transaction; ovr replaces the modelled read data when set.
    task automatic do_req(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] src,
                          input logic [255:0] data, input int hold,
                          input bit ovr, input logic [255:0] ovr_data);
        logic [4:0]   op;
        logic [255:0] exp_data;
        int           waited;
        op = cmd[4:0];
        @(negedge clk);
        udev_req_valid   = 1'b1;
        udev_req_cmd     = cmd;
        udev_req_dstaddr = dst;
        udev_req_srcaddr = src;
        udev_req_data    = data;
        waited = 0;
        while (!udev_req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            chk("req_ready_timeout", 1'b0, 1'b1);
            udev_req_valid = 1'b0;
            return;
        end
        exp_data = (op == 5'h01) ? (ovr ? ovr_data : model_read(dst, cmd, gpio_in)) : '0;
        if (op == 5'h03 || op == 5'h05) model_write(dst, cmd, data);
        @(posedge clk);
        @(negedge clk);
        udev_req_valid = 1'b0;
        if (op == 5'h01 || op == 5'h03) begin
            chk("resp_valid_next", udev_resp_valid, 1'b1);
            chk("req_ready_busy", udev_req_ready, 1'b0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", udev_resp_valid, 1'b1);
                chk("hold_ready", udev_req_ready, 1'b0);
            end
            chk("resp_cmd", udev_resp_cmd, {cmd[31:5], (op == 5'h01) ? 5'h02 : 5'h04});
            chk("resp_dst", udev_resp_dstaddr, src);
            chk("resp_src", udev_resp_srcaddr, dst);
            chk("resp_data", udev_resp_data, exp_data);
            udev_resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            udev_resp_ready = 1'b0;
            chk("resp_done", udev_resp_valid, 1'b0);
            chk("ready_after", udev_req_ready, 1'b1);
        end else begin
            chk("no_resp", udev_resp_valid, 1'b0);
            chk("stay_idle", udev_req_ready, 1'b1);
        end
        chk("gpio_out", gpio_out, m_out);
    endtask

    task automatic set_pins(input logic [127:0] v);
        @(negedge clk);
        gpio_in = v;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [127:0] pins;
        logic [31:0]  cmd;
        logic [63:0]  dst;
        logic [255:0] data;
        int           r;

        // Reset held with a pending request
        udev_req_valid = 1'b1;
        udev_req_cmd   = 32'h0000_0005;
        udev_req_data  = {8{32'hFFFF_FFFF}};
        repeat (3) begin
            @(negedge clk);
            chk("rst_gpio", gpio_out, '0);
            chk("rst_valid", udev_resp_valid, 1'b0);
            chk("rst_ready", udev_req_ready, 1'b0);
        end
        rst = 1'b0;
        udev_req_valid = 1'b0;
        #1;
        chk("ready_release", udev_req_ready, 1'b1);

        // Directed cases
        do_req(32'h0000_0305, 64'h4, 64'h0, 256'h1122_3344, 0, 1'b0, '0);
        chk("posted_word", gpio_out[63:32], 32'h1122_3344);
        do_req(32'h0000_0003, 64'h2F, 64'hABC0, 256'hA5, 4, 1'b0, '0);
        chk("write_top_byte", gpio_out[383:376], 8'hA5);
        for (int i = 0; i < 16; i++) pins[8*i +: 8] = 8'(8'h10 - i);
        set_pins(pins);
        do_req(32'h0000_0301, 64'hE, 64'h77, '0, 1, 1'b1, 256'h0102);
        do_req(32'h0000_0703, 64'h40, 64'h1, {8{32'hDEAD_BEEF}}, 0, 1'b0, '0);
        do_req(32'h0000_0007, 64'h0, 64'h2, {8{32'hDEAD_BEEF}}, 0, 1'b0, '0);
        do_req(32'h0000_0305, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, {8{32'hCAFE_F00D}}, 0, 1'b0, '0);

`ifdef UMI_GPIO_RESPONDER_SYNC_EN
        set_pins('0);
        gpio_in[7:0] = 8'h5A;
        do_req(32'h0000_0001, 64'h0, 64'h9, '0, 0, 1'b1, 256'h00);
        do_req(32'h0000_0001, 64'h0, 64'h9, '0, 0, 1'b1, 256'h5A);
`endif

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            cmd = $urandom;
            if ($urandom_range(0, 7) == 0) cmd[15:5] = {8'hFF, 3'h7};
            else cmd[15:5] = {8'($urandom_range(0, 40)), 3'($urandom_range(0, 2))};
            case (r)
                0, 1, 2: cmd[4:0] = 5'h01;
                3, 4:    cmd[4:0] = 5'h03;
                5, 6, 7: cmd[4:0] = 5'h05;
                8:       cmd[4:0] = 5'h07;
                default: cmd[4:0] = 5'($urandom);
            endcase
            dst = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                              : 64'($urandom_range(0, 60));
            for (int i = 0; i < 8; i++) data[32*i +: 32] = $urandom;
            if (cmd[4:0] == 5'h01) set_pins({$urandom, $urandom, $urandom, $urandom});
            do_req(cmd, dst, {$urandom, $urandom}, data, $urandom_range(0, 3), 1'b0, '0);
        end

        // Reset while a response is pending
        @(negedge clk);
        udev_req_valid = 1'b1;
        udev_req_cmd = 32'h0000_0003;
        udev_req_dstaddr = 64'h0;
        udev_req_data = 256'h77;
        @(posedge clk);
        @(negedge clk);
        udev_req_valid = 1'b0;
        chk("mid_pending", udev_resp_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", udev_resp_valid, 1'b0);
        chk("mid_rst_gpio", gpio_out, '0);
        @(negedge clk);
        rst = 1'b0;
        m_out = '0;
        #1;
        chk("mid_rst_ready", udev_req_ready, 1'b1);
        do_req(32'h0000_0105, 64'h10, 64'h0, 256'hBEEF, 0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
